// File: rtl/mips_core_pkg.sv
// Shared core types for the MIPS core. This file adds the perceptron feedback
// entry and the default perceptron geometry to the existing branch outcome type.
// No ports (package).
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    localparam int PERCEPTRON_HISTORY_SIZE = 62;
    localparam int PERCEPTRON_INDEX_WIDTH  = 10;
    localparam int PERCEPTRON_WEIGHT_BITS  = 8;
    localparam int PERCEPTRON_SUM_WIDTH    = 16;
    localparam int PERCEPTRON_THRESHOLD    = 134;
    localparam int PERCEPTRON_FIFO_DEPTH   = 4;
    localparam int PERCEPTRON_MAX_WAIT     = 8;

    // Resolved-branch feedback as produced by the back end (default geometry).
    typedef struct packed {
        logic [PERCEPTRON_INDEX_WIDTH-1:0]  index;
        logic [PERCEPTRON_HISTORY_SIZE-1:0] ghr;
        logic [PERCEPTRON_SUM_WIDTH-1:0]    sum;
        BranchOutcome                       prediction;
        BranchOutcome                       outcome;
    } perceptron_fb_entry_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR
    } perceptron_state_t;

endpackage

// File: rtl/perceptron_update_scheduler_weight_update.sv
// perceptron_weight_update: combinational training step for one weight row.
// Each weight moves +1 when the outcome agrees with its history bit (bias uses
// a constant 1) and -1 otherwise, saturating at the signed range limits.
// Ports:
//   row_in  - current row, weight i at [i*WEIGHT_BITS +: WEIGHT_BITS]
//   ghr     - history snapshot used at prediction time
//   taken   - resolved direction (1 = taken)
//   row_out - trained row, same layout as row_in
module perceptron_weight_update #(
    parameter int HISTORY_SIZE = 62,
    parameter int WEIGHT_BITS  = 8
) (
    input  logic [(HISTORY_SIZE+1)*WEIGHT_BITS-1:0] row_in,
    input  logic [HISTORY_SIZE-1:0]                 ghr,
    input  logic                                    taken,
    output logic [(HISTORY_SIZE+1)*WEIGHT_BITS-1:0] row_out
);

    localparam logic signed [WEIGHT_BITS-1:0] W_MAX = {1'b0, {(WEIGHT_BITS-1){1'b1}}};
    localparam logic signed [WEIGHT_BITS-1:0] W_MIN = {1'b1, {(WEIGHT_BITS-1){1'b0}}};
    localparam logic signed [WEIGHT_BITS-1:0] W_ONE = 1;

    genvar gi;
    generate
        for (gi = 0; gi < HISTORY_SIZE + 1; gi++) begin : g_weight
            logic signed [WEIGHT_BITS-1:0] w_cur;
            logic signed [WEIGHT_BITS-1:0] w_new;
            logic                          hbit;
            logic                          agree;

            assign w_cur = row_in[gi*WEIGHT_BITS +: WEIGHT_BITS];

            if (gi == 0) begin : g_bias
                assign hbit = 1'b1;
            end else begin : g_hist
                assign hbit = ghr[gi-1];
            end

            assign agree = (taken == hbit);

            always_comb begin
                w_new = w_cur;
                if (agree) begin
                    if (w_cur != W_MAX) w_new = w_cur + W_ONE;
                end else begin
                    if (w_cur != W_MIN) w_new = w_cur - W_ONE;
                end
            end

            assign row_out[gi*WEIGHT_BITS +: WEIGHT_BITS] = w_new;
        end
    endgenerate

endmodule

// File: rtl/perceptron_update_scheduler.sv
// perceptron_update_scheduler: owns the single-port perceptron weight RAM.
// Zero-sweeps the RAM after reset, then arbitrates between front-end prediction
// reads and queued training updates (read, train, write back one row).
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   i_fb_* / o_fb_ready        - resolved-branch feedback (valid/ready)
//   i_pred_valid/index         - prediction row read request
//   o_pred_ready               - read granted this cycle
//   o_pred_rsp_valid           - i_ram_rdata holds the granted row
//   o_ram_en/we/addr/wdata     - RAM command, i_ram_rdata one cycle after a read
//   o_init_done                - post-reset sweep finished
//   o_train_count              - number of rows written by training (wraps)
module perceptron_update_scheduler
    import mips_core_pkg::*;
#(
    parameter int HISTORY_SIZE = PERCEPTRON_HISTORY_SIZE,
    parameter int INDEX_WIDTH  = PERCEPTRON_INDEX_WIDTH,
    parameter int WEIGHT_BITS  = PERCEPTRON_WEIGHT_BITS,
    parameter int SUM_WIDTH    = PERCEPTRON_SUM_WIDTH,
    parameter int THRESHOLD    = PERCEPTRON_THRESHOLD,
    parameter int FIFO_DEPTH   = PERCEPTRON_FIFO_DEPTH,
    parameter int MAX_WAIT     = PERCEPTRON_MAX_WAIT
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    i_fb_valid,
    output logic                                    o_fb_ready,
    input  logic [INDEX_WIDTH-1:0]                  i_fb_index,
    input  logic [HISTORY_SIZE-1:0]                 i_fb_ghr,
    input  logic [SUM_WIDTH-1:0]                    i_fb_sum,
    input  BranchOutcome                            i_fb_prediction,
    input  BranchOutcome                            i_fb_outcome,
    input  logic                                    i_pred_valid,
    input  logic [INDEX_WIDTH-1:0]                  i_pred_index,
    output logic                                    o_pred_ready,
    output logic                                    o_pred_rsp_valid,
    output logic                                    o_ram_en,
    output logic                                    o_ram_we,
    output logic [INDEX_WIDTH-1:0]                  o_ram_addr,
    output logic [(HISTORY_SIZE+1)*WEIGHT_BITS-1:0] o_ram_wdata,
    input  logic [(HISTORY_SIZE+1)*WEIGHT_BITS-1:0] i_ram_rdata,
    output logic                                    o_init_done,
    output logic [15:0]                             o_train_count
);

    localparam int ROW_BITS = (HISTORY_SIZE + 1) * WEIGHT_BITS;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [PTR_W:0]     FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT    = WAIT_W'(MAX_WAIT);
    localparam logic [SUM_WIDTH:0] THRESH_EXT    = (SUM_WIDTH+1)'(THRESHOLD);

    // Only the fields the update needs are queued.
    typedef struct packed {
        logic [INDEX_WIDTH-1:0]  index;
        logic [HISTORY_SIZE-1:0] ghr;
        logic                    taken;
    } queued_entry_t;

    perceptron_state_t state_reg, state_next;
    logic [INDEX_WIDTH-1:0] row_ctr_reg;
    logic [WAIT_W-1:0]      wait_ctr_reg;
    logic                   init_done_reg;
    logic [15:0]            train_count_reg;
    logic                   pred_rsp_valid_reg;
    logic [ROW_BITS-1:0]    upd_row_reg;
    logic [ROW_BITS-1:0]    upd_row_next;

    queued_entry_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]         count_reg;
    logic                   fifo_full, fifo_empty, push, pop;
    queued_entry_t          head, push_entry;

    // |sum| in one extra bit so the most negative sum stays representable.
    logic [SUM_WIDTH:0]     sum_ext, sum_abs;
    logic                   fb_trains;
    logic                   update_wins;
    logic                   pred_grant;

    assign sum_ext   = {i_fb_sum[SUM_WIDTH-1], i_fb_sum};
    assign sum_abs   = sum_ext[SUM_WIDTH] ? (~sum_ext + 1'b1) : sum_ext;
    assign fb_trains = (i_fb_prediction != i_fb_outcome) || (sum_abs <= THRESH_EXT);

    assign fifo_full  = (count_reg == FIFO_FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign o_fb_ready = !fifo_full && (state_reg != S_INIT);
    assign push       = i_fb_valid && o_fb_ready && fb_trains;
    assign pop        = (state_reg == S_WR);
    assign head       = fifo_mem[rd_ptr_reg];

    assign push_entry.index = i_fb_index;
    assign push_entry.ghr   = i_fb_ghr;
    assign push_entry.taken = (i_fb_outcome == TAKEN);

    assign update_wins = !i_pred_valid || fifo_full || (wait_ctr_reg == WAIT_LIMIT);

    perceptron_weight_update #(
        .HISTORY_SIZE (HISTORY_SIZE),
        .WEIGHT_BITS  (WEIGHT_BITS)
    ) u_weight_update (
        .row_in  (i_ram_rdata),
        .ghr     (head.ghr),
        .taken   (head.taken),
        .row_out (upd_row_next)
    );

    always_comb begin
        state_next  = state_reg;
        pred_grant  = 1'b0;
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = i_pred_index;
        o_ram_wdata = '0;
        case (state_reg)
            S_INIT: begin
                // Keep the RAM quiet while reset is still held.
                o_ram_en   = rst_n;
                o_ram_we   = rst_n;
                o_ram_addr = row_ctr_reg;
                if (&row_ctr_reg) state_next = S_IDLE;
            end
            S_IDLE: begin
                pred_grant = i_pred_valid;
                if (!fifo_empty) state_next = S_RD;
            end
            S_RD: begin
                if (update_wins) begin
                    o_ram_en   = 1'b1;
                    o_ram_addr = head.index;
                    state_next = S_WAIT;
                end else begin
                    pred_grant = 1'b1;
                end
            end
            S_WAIT: begin
                pred_grant = i_pred_valid;
                state_next = S_WR;
            end
            S_WR: begin
                o_ram_en    = 1'b1;
                o_ram_we    = 1'b1;
                o_ram_addr  = head.index;
                o_ram_wdata = upd_row_reg;
                // Occupancy after this cycle's pop (and any same-cycle push).
                state_next  = ((count_reg - 1'b1 + {{PTR_W{1'b0}}, push}) != '0) ? S_RD : S_IDLE;
            end
            default: state_next = S_INIT;
        endcase
        if (pred_grant) begin
            o_ram_en   = 1'b1;
            o_ram_addr = i_pred_index;
        end
    end

    assign o_pred_ready     = pred_grant;
    assign o_pred_rsp_valid = pred_rsp_valid_reg;
    assign o_init_done      = init_done_reg;
    assign o_train_count    = train_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_INIT;
            row_ctr_reg        <= '0;
            wait_ctr_reg       <= '0;
            init_done_reg      <= 1'b0;
            train_count_reg    <= '0;
            pred_rsp_valid_reg <= 1'b0;
            upd_row_reg        <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
        end else begin
            state_reg          <= state_next;
            pred_rsp_valid_reg <= pred_grant;
            if (state_reg == S_INIT) begin
                row_ctr_reg <= row_ctr_reg + 1'b1;
                if (state_next == S_IDLE) init_done_reg <= 1'b1;
            end
            if (state_reg == S_RD) begin
                wait_ctr_reg <= update_wins ? '0 : wait_ctr_reg + 1'b1;
            end
            // Read data arrives in WAIT; train it here and write it back in WR.
            if (state_reg == S_WAIT) upd_row_reg <= upd_row_next;
            if (state_reg == S_WR) train_count_reg <= train_count_reg + 1'b1;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= push_entry;
    end

endmodule

// File: tb/tb_perceptron_update_scheduler.sv
// Directed bench for perceptron_update_scheduler with a behavioural weight RAM.
module tb_perceptron_update_scheduler;
    import mips_core_pkg::*;

    localparam int HS = 62;
    localparam int IW = 4;
    localparam int WB = 8;
    localparam int SW = 16;
    localparam int RB = (HS + 1) * WB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_fb_valid;
    logic          o_fb_ready;
    logic [IW-1:0] i_fb_index;
    logic [HS-1:0] i_fb_ghr;
    logic [SW-1:0] i_fb_sum;
    BranchOutcome  i_fb_prediction, i_fb_outcome;
    logic          i_pred_valid;
    logic [IW-1:0] i_pred_index;
    logic          o_pred_ready, o_pred_rsp_valid;
    logic          o_ram_en, o_ram_we;
    logic [IW-1:0] o_ram_addr;
    logic [RB-1:0] o_ram_wdata, i_ram_rdata;
    logic          o_init_done;
    logic [15:0]   o_train_count;

    perceptron_update_scheduler #(
        .HISTORY_SIZE (HS), .INDEX_WIDTH (IW), .WEIGHT_BITS (WB), .SUM_WIDTH (SW),
        .THRESHOLD (134), .FIFO_DEPTH (4), .MAX_WAIT (8)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .i_fb_valid (i_fb_valid), .o_fb_ready (o_fb_ready), .i_fb_index (i_fb_index),
        .i_fb_ghr (i_fb_ghr), .i_fb_sum (i_fb_sum), .i_fb_prediction (i_fb_prediction),
        .i_fb_outcome (i_fb_outcome), .i_pred_valid (i_pred_valid), .i_pred_index (i_pred_index),
        .o_pred_ready (o_pred_ready), .o_pred_rsp_valid (o_pred_rsp_valid),
        .o_ram_en (o_ram_en), .o_ram_we (o_ram_we), .o_ram_addr (o_ram_addr),
        .o_ram_wdata (o_ram_wdata), .i_ram_rdata (i_ram_rdata),
        .o_init_done (o_init_done), .o_train_count (o_train_count)
    );

    // Behavioural RAM plus passive monitor counters.
    logic [RB-1:0] mem [16];
    logic [RB-1:0] rdata_reg;
    logic          preload_en = 1'b0;
    logic [IW-1:0] preload_addr = '0;
    logic [RB-1:0] preload_data = '0;
    assign i_ram_rdata = rdata_reg;

    int cyc = 0;
    int init_writes, init_bad, pred_in_init, pred_in_wr, upd_writes;
    int grants, rsps, rsp_bad, upd_rd_cycle, wr_cycle;
    logic [IW-1:0] last_pred_addr;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload_en) mem[preload_addr] <= preload_data;
        else if (o_ram_en) begin
            if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
            else          rdata_reg <= mem[o_ram_addr];
        end
        if (!rst_n) begin
            init_writes <= 0; init_bad <= 0; pred_in_init <= 0; pred_in_wr <= 0;
            upd_writes <= 0; grants <= 0; rsps <= 0; rsp_bad <= 0;
            upd_rd_cycle <= 0; wr_cycle <= 0; last_pred_addr <= '0;
        end else begin
            if (o_ram_en && o_ram_we) begin
                if (!o_init_done) begin
                    init_writes <= init_writes + 1;
                    if (o_ram_addr != init_writes[IW-1:0] || o_ram_wdata != '0)
                        init_bad <= init_bad + 1;
                end else begin
                    upd_writes <= upd_writes + 1;
                    wr_cycle <= cyc;
                    if (o_pred_ready) pred_in_wr <= pred_in_wr + 1;
                end
            end
            if (o_ram_en && !o_ram_we && !o_pred_ready && o_init_done) upd_rd_cycle <= cyc;
            if (o_pred_ready && !o_init_done) pred_in_init <= pred_in_init + 1;
            if (o_pred_ready) begin
                grants <= grants + 1;
                last_pred_addr <= o_ram_addr;
            end
            if (o_pred_rsp_valid) begin
                rsps <= rsps + 1;
                if (i_ram_rdata !== mem[last_pred_addr]) rsp_bad <= rsp_bad + 1;
            end
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    function automatic logic [RB-1:0] fill_row(input logic [WB-1:0] v);
        logic [RB-1:0] r;
        for (int i = 0; i < HS + 1; i++) r[i*WB +: WB] = v;
        return r;
    endfunction

    // Offer one feedback entry; returns at the negedge after it was accepted.
    task automatic send_fb(input int idx, input logic [HS-1:0] ghr, input int sum,
                           input BranchOutcome p, input BranchOutcome o);
        i_fb_index = idx[IW-1:0];
        i_fb_ghr = ghr;
        i_fb_sum = sum[SW-1:0];
        i_fb_prediction = p;
        i_fb_outcome = o;
        i_fb_valid = 1'b1;
        for (int n = 0; n < 50 && !o_fb_ready; n++) @(negedge clk);
        check("fb_accept", o_fb_ready, 1);
        @(negedge clk);
        i_fb_valid = 1'b0;
    endtask

    task automatic wait_train(input int exp_count);
        for (int n = 0; n < 300 && o_train_count != exp_count[15:0]; n++) @(negedge clk);
        @(negedge clk);
        check("train_count", o_train_count, exp_count);
    endtask

    logic [RB-1:0] exp_row;
    int n_grants;
    int k;

    initial begin
        i_fb_valid = 1'b0; i_fb_index = '0; i_fb_ghr = '0; i_fb_sum = '0;
        i_fb_prediction = NOT_TAKEN; i_fb_outcome = NOT_TAKEN;
        i_pred_valid = 1'b1; i_pred_index = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_init_done", o_init_done, 0);
        check("rst_fb_ready", o_fb_ready, 0);
        check("rst_pred_ready", o_pred_ready, 0);
        check("rst_rsp_valid", o_pred_rsp_valid, 0);
        check("rst_ram_en", o_ram_en, 0);
        check("rst_ram_we", o_ram_we, 0);
        check("rst_train_count", o_train_count, 0);

        // Init sweep: 16 zero writes, done visible after the 16th
        rst_n = 1'b1;
        for (k = 1; k < 40; k++) begin
            @(negedge clk);
            if (o_init_done) break;
        end
        check("init_done_cycle", k, 16);
        check("init_writes", init_writes, 16);
        check("init_seq_bad", init_bad, 0);
        check("pred_in_init", pred_in_init, 0);
        i_pred_valid = 1'b0;

        // Training entry: mispredict, all-ones history -> every weight +1
        send_fb(5, '1, 200, NOT_TAKEN, TAKEN);
        wait_train(1);
        check("row5_plus1", mem[5], fill_row(8'h01));
        check("rd_to_wr_latency", wr_cycle - upd_rd_cycle, 2);

        // Filter: |sum| above threshold with correct prediction is dropped
        send_fb(6, '0, -135, NOT_TAKEN, NOT_TAKEN);
        send_fb(6, '0, -32768, TAKEN, TAKEN);
        repeat (8) @(negedge clk);
        check("filtered_no_write", upd_writes, 1);
        check("filtered_count", o_train_count, 1);
        send_fb(6, '0, -134, NOT_TAKEN, NOT_TAKEN);
        wait_train(2);
        exp_row = fill_row(8'h01);
        exp_row[WB-1:0] = 8'hFF;
        check("row6_boundary", mem[6], exp_row);

        // Saturation: weights already at the limit in the training direction
        for (int i = 0; i < HS + 1; i++)
            exp_row[i*WB +: WB] = (i == 0 || (i % 2) == 1) ? 8'h7F : 8'h80;
        preload_addr = 4'd7; preload_data = exp_row; preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
        send_fb(7, {31{2'b01}}, 0, TAKEN, TAKEN);
        wait_train(3);
        check("row7_saturated", mem[7], exp_row);

        // Contention: continuous prediction traffic, one queued update
        i_pred_valid = 1'b1; i_pred_index = 4'd0;
        send_fb(8, '1, 0, TAKEN, TAKEN);
        n_grants = 0;
        for (int n = 0; n < 40; n++) begin
            if (o_ram_en && !o_ram_we && !o_pred_ready) break;
            if (o_pred_ready) n_grants++;
            @(negedge clk);
        end
        check("pred_grants_before_update", n_grants, 9);
        wait_train(4);
        check("row8_plus1", mem[8], fill_row(8'h01));

        // Full queue: update read wins at once
        send_fb(9, '1, 0, TAKEN, TAKEN);
        send_fb(9, '1, 0, TAKEN, TAKEN);
        send_fb(9, '1, 0, TAKEN, TAKEN);
        send_fb(9, '1, 0, TAKEN, TAKEN);
        check("full_fb_ready", o_fb_ready, 0);
        check("full_pred_ready", o_pred_ready, 0);
        check("full_upd_read", {o_ram_en, o_ram_we, o_ram_addr}, {1'b1, 1'b0, 4'd9});
        wait_train(8);
        check("row9_plus4", mem[9], fill_row(8'h04));
        check("pred_in_wr", pred_in_wr, 0);
        i_pred_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rsp_per_grant", rsps, grants);
        check("rsp_data_bad", rsp_bad, 0);

        // Back-to-back updates of one row serialise
        send_fb(10, '1, 0, TAKEN, TAKEN);
        send_fb(10, '1, 0, TAKEN, TAKEN);
        wait_train(10);
        check("row10_plus2", mem[10], fill_row(8'h02));

        // Reset mid-update: queue lost, sweep reruns
        send_fb(11, '1, 0, TAKEN, TAKEN);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_train_count", o_train_count, 0);
        check("midrst_init_done", o_init_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 40 && !o_init_done; n++) @(negedge clk);
        check("reinit_writes", init_writes, 16);
        repeat (10) @(negedge clk);
        check("reinit_row5", mem[5], 0);
        check("reinit_no_update", upd_writes, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/perceptron_update_scheduler.md
# perceptron_update_scheduler

Sequences all accesses to the single-port perceptron weight RAM. It shares that RAM between front-end prediction reads and back-end training updates. Resolved-branch feedback is filtered, queued, and retired as a read-modify-write of one weight row. The block also performs the post-reset zero-initialisation sweep of the RAM. It sits between the branch predictor front end, the feedback path from branch resolution, and the weight RAM macro.

## Interface
- HISTORY_SIZE, 62, global history bits per row (WEIGHT_NUMBER = HISTORY_SIZE+1, weight 0 = bias)
- INDEX_WIDTH, 10, RAM row address width (2^INDEX_WIDTH rows)
- WEIGHT_BITS, 8, signed weight width
- SUM_WIDTH, 16, signed perceptron sum width carried in feedback
- THRESHOLD, 134, training threshold on |sum|
- FIFO_DEPTH, 4, feedback queue entries (power of 2)
- MAX_WAIT, 8, cycles an update read may be deferred before it is forced
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_fb_valid  in  1  feedback entry offered
- o_fb_ready  out  1  feedback accepted when valid && ready
- i_fb_index  in  INDEX_WIDTH  row used at prediction time
- i_fb_ghr  in  HISTORY_SIZE  GHR snapshot used at prediction time
- i_fb_sum  in  SUM_WIDTH  signed sum computed at prediction time
- i_fb_prediction, i_fb_outcome  in  mips_core_pkg::BranchOutcome  predicted / actual direction
- i_pred_valid  in  1  prediction row read requested
- i_pred_index  in  INDEX_WIDTH  row to read
- o_pred_ready  out  1  read granted this cycle
- o_pred_rsp_valid  out  1  i_ram_rdata holds the granted prediction row (one cycle after grant)
- o_ram_en, o_ram_we  out  1  RAM access strobe / write enable
- o_ram_addr  out  INDEX_WIDTH  RAM row address
- o_ram_wdata  out  WEIGHT_NUMBER*WEIGHT_BITS  row write data; weight i at [i*WEIGHT_BITS +: WEIGHT_BITS]
- i_ram_rdata  in  WEIGHT_NUMBER*WEIGHT_BITS  read data, valid the cycle after o_ram_en && !o_ram_we
- o_init_done  out  1  RAM sweep complete
- o_train_count  out  16  updates written, wraps

## Operation
- **Feedback filter:** on accept, the entry is pushed only if prediction != outcome or |sum| <= THRESHOLD.
  - |sum| is computed in SUM_WIDTH+1 bits, so the most negative sum does not overflow.
  - A non-training entry is accepted and dropped.
- **o_fb_ready** = !fifo_full. There is no push bypass at full, even when a pop happens the same cycle.
- **FSM states:** INIT, IDLE, RD, WAIT, WR.
  - INIT: write an all-zero row to row_ctr each cycle, row_ctr 0 → 2^INDEX_WIDTH−1. Then set o_init_done=1 and go to IDLE. Prediction and feedback are not accepted in INIT.
  - IDLE: if the FIFO is non-empty → RD.
  - RD: wait for a port grant on the head entry's index (read).
    - Update wins if !i_pred_valid, or the FIFO is full, or wait_ctr == MAX_WAIT. Otherwise the prediction wins and wait_ctr increments.
    - On update grant → WAIT, wait_ctr cleared.
  - WAIT: capture i_ram_rdata. The port is free for a prediction read. → WR.
  - WR: write the updated row and pop the FIFO; o_train_count++. The port is always owned by the update, and o_pred_ready=0. → RD if the FIFO is still non-empty after the pop, else IDLE.
- **Row update:** t = (outcome==TAKEN).
  - hbit = 1 for i=0, and ghr[i−1] for i≥1.
  - w_i += (t==hbit) ? +1 : −1, saturated to [−2^(WEIGHT_BITS−1), 2^(WEIGHT_BITS−1)−1].
- **o_pred_ready** = i_pred_valid && state ∉ {INIT, WR} && !(state==RD && update wins).
- **Same-index hazard:** a prediction read of a row between its RD and WR returns the pre-update row. This is accepted behaviour.
- **Consecutive updates to one row** are serialised: the WR completes before the next RD.

## Timing
- **Reset values:** state=INIT, row_ctr=0, FIFO empty, wait_ctr=0, o_init_done=0, o_train_count=0, o_fb_ready=0, o_pred_ready=0, o_pred_rsp_valid=0, o_ram_en=0, o_ram_we=0.
- **Reset mid-operation:** an in-flight update is abandoned and queued feedback is lost. INIT reruns fully.
- **Init:** exactly 2^INDEX_WIDTH cycles of writes. o_init_done rises the following cycle.
- **Update latency:** minimum 3 cycles from RD entry to WR (RD, WAIT, WR). Sustained throughput is one update per 3 cycles.
- **Prediction read:** grant in cycle N → o_pred_rsp_valid and data in cycle N+1.
- **Deferral bound:** an update read is deferred at most MAX_WAIT cycles.
- **Enqueue:** an accepted training entry is visible to the FSM the next cycle.

## Structure
- mips_core_pkg: BranchOutcome (existing), plus a perceptron_fb_entry_t struct (index, ghr, sum, prediction, outcome) and default PERCEPTRON_* constants.
- Sub-module perceptron_weight_update: combinational row-in/row-out saturating update, parameterised by HISTORY_SIZE and WEIGHT_BITS.
- FIFO and FSM are inline.

## Test plan
- **Reset, INIT_SWEEP=1, INDEX_WIDTH=4:** 16 consecutive writes of zero to rows 0..15. o_init_done=1 at cycle 17. No pred_ready before then.
- **Training entry:** feedback idx=5, ghr=all-ones, sum=200, pred=NOT_TAKEN, outcome=TAKEN, RAM row all 0 → WR 3 cycles after RD writes all weights +1. o_train_count=1.
- **Filtered entry:** sum=−135, pred=NOT_TAKEN, outcome=NOT_TAKEN → accepted, no RAM access, count unchanged. The same entry with sum=−134 trains.
- **Saturation:** row weights = +127 / −128, entry that pushes each outward → row unchanged.
- **Contention:** continuous i_pred_valid with 1 queued entry → update read forced after 8 deferrals. With FIFO full → update wins immediately. o_pred_ready=0 in every WR.
- **Back-to-back:** two entries to the same index → second RD occurs after first WR. The final row reflects both increments (+2).
